// File: rtl/fx2_cmd_pkg.sv
// Shared constants and state encodings for the FX2 EP2 OUT command reader.
package fx2_cmd_pkg;
  localparam logic [7:0] MAGIC_DEF    = 8'hAA;
  localparam logic [7:0] OP_WRITE_DEF = 8'h01;
  localparam int         FRAME_LEN    = 4;

  typedef enum logic [2:0] {
    BUS_IDLE, BUS_WAIT_GNT, BUS_SETUP, BUS_STROBE, BUS_SETTLE, BUS_RELEASE
  } bus_state_t;

  typedef enum logic [1:0] {
    P_WAIT_MAGIC, P_OPCODE, P_ADDR, P_DATA
  } parse_state_t;
endpackage

// File: rtl/fx2_cmd_reader_parser.sv
// Frame parser: MAGIC, opcode, addr, data -> one-cycle register write strobe.
module fx2_cmd_parser import fx2_cmd_pkg::*; #(
  parameter logic [7:0] MAGIC    = MAGIC_DEF,
  parameter logic [7:0] OP_WRITE = OP_WRITE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       reg_wr,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_data,
  output logic [7:0] bad_frame_count
);
  parse_state_t pstate_q, pstate_d;
  logic       wr_q, wr_d;
  logic [7:0] addr_q, addr_d, data_q, data_d, bad_q, bad_d;
  logic [7:0] addr_lat_q, addr_lat_d;

  always_comb begin
    pstate_d   = pstate_q;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    bad_d      = bad_q;
    addr_lat_d = addr_lat_q;
    if (byte_valid) begin
      unique case (pstate_q)
        P_WAIT_MAGIC: if (byte_data == MAGIC) pstate_d = P_OPCODE;
        P_OPCODE: begin
          if (byte_data == OP_WRITE) pstate_d = P_ADDR;
          else begin
            pstate_d = P_WAIT_MAGIC;
            if (bad_q != 8'hFF) bad_d = bad_q + 8'd1;
          end
        end
        P_ADDR: begin
          addr_lat_d = byte_data;
          pstate_d   = P_DATA;
        end
        P_DATA: begin
          // Output address is only updated on a complete frame so it holds between writes.
          wr_d     = 1'b1;
          addr_d   = addr_lat_q;
          data_d   = byte_data;
          pstate_d = P_WAIT_MAGIC;
        end
        default: pstate_d = P_WAIT_MAGIC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstate_q   <= P_WAIT_MAGIC;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      bad_q      <= '0;
      addr_lat_q <= '0;
    end else begin
      pstate_q   <= pstate_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      bad_q      <= bad_d;
      addr_lat_q <= addr_lat_d;
    end
  end

  assign reg_wr          = wr_q;
  assign reg_addr        = addr_q;
  assign reg_data        = data_q;
  assign bad_frame_count = bad_q;
endmodule

// File: rtl/fx2_cmd_reader.sv
// FX2 slave-FIFO EP2 OUT reader: bus arbitration, burst byte draining, frame parsing.
module fx2_cmd_reader import fx2_cmd_pkg::*; #(
  parameter logic [1:0] EP_ADDR   = 2'b00,
  parameter logic [7:0] MAGIC     = MAGIC_DEF,
  parameter logic [7:0] OP_WRITE  = OP_WRITE_DEF,
  parameter int         MAX_BURST = 16
) (
  input  logic       fx2_clk,
  input  logic       reset,
  input  logic [2:0] fx2_flags,
  input  logic [7:0] fx2_fd,
  output logic       fx2_slrd,
  output logic       fx2_sloe,
  output logic [1:0] fx2_fifoadr,
  output logic       bus_req,
  input  logic       bus_gnt,
  output logic       reg_wr,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_data,
  output logic [7:0] bad_frame_count,
  output logic       busy
);
  bus_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       slrd_q, slrd_d, sloe_q, sloe_d, req_q, req_d, busy_q, busy_d;
  logic       unused_flags;

  assign unused_flags = ^fx2_flags[2:1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      BUS_IDLE:     if (fx2_flags[0]) state_d = BUS_WAIT_GNT;
      BUS_WAIT_GNT: if (bus_gnt) state_d = BUS_SETUP;
      BUS_SETUP: begin
        cnt_d   = '0;
        state_d = (fx2_flags[0] && bus_gnt) ? BUS_STROBE : BUS_RELEASE;
      end
      BUS_STROBE: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = BUS_SETTLE;
      end
      BUS_SETTLE:
        state_d = (fx2_flags[0] && bus_gnt && (cnt_q < 8'(MAX_BURST))) ? BUS_STROBE : BUS_RELEASE;
      BUS_RELEASE:  state_d = BUS_IDLE;
      default:      state_d = BUS_IDLE;
    endcase
    // Pin levels are registered from the next state so they line up with the state they belong to.
    slrd_d = (state_d != BUS_STROBE);
    sloe_d = !(state_d inside {BUS_SETUP, BUS_STROBE, BUS_SETTLE});
    req_d  = state_d inside {BUS_WAIT_GNT, BUS_SETUP, BUS_STROBE, BUS_SETTLE};
    busy_d = (state_d != BUS_IDLE);
  end

  always_ff @(posedge fx2_clk or posedge reset) begin
    if (reset) begin
      state_q <= BUS_IDLE;
      cnt_q   <= '0;
      slrd_q  <= 1'b1;
      sloe_q  <= 1'b1;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slrd_q  <= slrd_d;
      sloe_q  <= sloe_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
    end
  end

  assign fx2_slrd    = slrd_q;
  assign fx2_sloe    = sloe_q;
  assign fx2_fifoadr = EP_ADDR;
  assign bus_req     = req_q;
  assign busy        = busy_q;

  // The byte on fx2_fd is captured by the parser at the edge that ends the STROBE cycle.
  fx2_cmd_parser #(.MAGIC(MAGIC), .OP_WRITE(OP_WRITE)) u_parser (
    .clk            (fx2_clk),
    .rst            (reset),
    .byte_valid     (state_q == BUS_STROBE),
    .byte_data      (fx2_fd),
    .reg_wr         (reg_wr),
    .reg_addr       (reg_addr),
    .reg_data       (reg_data),
    .bad_frame_count(bad_frame_count)
  );
endmodule

// File: tb/tb_fx2_cmd_reader.sv
// Bench for fx2_cmd_reader: FIFO emulation, frame-level reference model, per-cycle compare.
module tb_fx2_cmd_reader;
  import fx2_cmd_pkg::*;

  logic       fx2_clk = 1'b0, reset = 1'b1;
  logic [2:0] fx2_flags = 3'b000;
  logic [7:0] fx2_fd = 8'h00;
  logic       fx2_slrd, fx2_sloe, bus_req, bus_gnt, reg_wr, busy;
  logic [1:0] fx2_fifoadr;
  logic [7:0] reg_addr, reg_data, bad_frame_count;

  int tests = 0, fails = 0;
  int gnt_mode = 0;          // 0: follow bus_req, 1: forced gnt_val, 2: random while requested
  logic gnt_val = 1'b0, gnt_rnd = 1'b1;
  assign bus_gnt = (gnt_mode == 0) ? bus_req : (gnt_mode == 1) ? gnt_val : (bus_req & gnt_rnd);

  fx2_cmd_reader #(.EP_ADDR(2'b00), .MAX_BURST(16)) dut (
    .fx2_clk(fx2_clk), .reset(reset), .fx2_flags(fx2_flags), .fx2_fd(fx2_fd),
    .fx2_slrd(fx2_slrd), .fx2_sloe(fx2_sloe), .fx2_fifoadr(fx2_fifoadr),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_data(reg_data), .bad_frame_count(bad_frame_count), .busy(busy)
  );

  always #5 fx2_clk = ~fx2_clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // FIFO contents and frame-level model state
  byte unsigned fifo[$];
  byte unsigned m_buf[$];
  int   m_bad = 0, m_writes = 0;
  logic [7:0] m_la = 0, m_ld = 0;
  bit   exp_wr = 0, pending_pop = 0, prev_low = 0, prev_req = 0, prev_busy = 0;
  int   strobes = 0, cur_burst = 0;
  int   bursts[$];
  logic [15:0] got_wr[$];

  // Frames are recognised by content: a buffer that starts with MAGIC and fills to FRAME_LEN.
  task automatic model_byte(input byte unsigned b);
    if (m_buf.size() == 0) begin
      if (b == MAGIC_DEF) m_buf.push_back(b);
    end else begin
      m_buf.push_back(b);
      if (m_buf.size() == 2 && m_buf[1] != OP_WRITE_DEF) begin
        m_bad = (m_bad >= 255) ? 255 : m_bad + 1;
        m_buf.delete();
      end else if (m_buf.size() == FRAME_LEN) begin
        exp_wr = 1; m_la = m_buf[2]; m_ld = m_buf[3]; m_writes++;
        m_buf.delete();
      end
    end
  endtask

  always @(negedge fx2_clk) begin
    if (reset) begin
      m_buf.delete(); m_bad = 0; m_la = 0; m_ld = 0;
      exp_wr = 0; pending_pop = 0; prev_low = 0; prev_req = 0; prev_busy = 0; cur_burst = 0;
    end else begin
      chk("reg_wr", reg_wr, exp_wr);
      chk("reg_addr", reg_addr, m_la);
      chk("reg_data", reg_data, m_ld);
      chk("bad_cnt", bad_frame_count, m_bad);
      chk("fifoadr", fx2_fifoadr, 0);
      if (reg_wr) got_wr.push_back({reg_addr, reg_data});
      if (!fx2_slrd) begin
        chk("slrd_needs_oe", fx2_sloe, 0);
        chk("slrd_back_to_back", prev_low, 0);
        chk("slrd_on_empty", fifo.size() != 0, 1);
      end
      if (!fx2_sloe) chk("oe_without_req", bus_req, 1);
      if (bus_req) chk("busy_with_req", busy, 1);
      if (bus_req && !prev_req) begin
        chk("idle_gap", prev_busy, 0);
        cur_burst = 0;
      end
      if (!bus_req && prev_req) bursts.push_back(cur_burst);
      exp_wr = 0;
      if (pending_pop && fifo.size() != 0) void'(fifo.pop_front());
      pending_pop = 0;
      if (!fx2_slrd && fifo.size() != 0) begin
        model_byte(fifo[0]);
        pending_pop = 1; strobes++; cur_burst++;
      end
      prev_low = !fx2_slrd; prev_req = bus_req; prev_busy = busy;
    end
    gnt_rnd   = ($urandom_range(0, 3) != 0);
    fx2_fd    = (fifo.size() != 0) ? fifo[0] : 8'h00;
    fx2_flags = {2'b00, fifo.size() != 0};
  end

  task automatic push(input byte unsigned b);
    fifo.push_back(b);
  endtask

  task automatic push_frame(input byte unsigned a, input byte unsigned b,
                            input byte unsigned c, input byte unsigned d);
    push(a); push(b); push(c); push(d);
  endtask

  task automatic drain(input int budget);
    int n = 0, quiet = 0;
    while (quiet < 4 && n < budget) begin
      @(posedge fx2_clk); #2;
      n++;
      if (fifo.size() == 0 && !busy) quiet++; else quiet = 0;
    end
    tests++;
    if (quiet < 4) begin
      fails++;
      $display("FAIL drain_timeout: fifo %0d bytes left, busy %0b after %0d cycles", fifo.size(), busy, n);
    end
  endtask

  task automatic start_case();
    got_wr.delete(); bursts.delete(); strobes = 0;
  endtask

  task automatic chk_wr(input int idx, input logic [15:0] exp);
    chk($sformatf("write_%0d", idx), (idx < got_wr.size()) ? int'(got_wr[idx]) : -1, int'(exp));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_slrd"}, fx2_slrd, 1);   chk({tag, "_sloe"}, fx2_sloe, 1);
    chk({tag, "_req"}, bus_req, 0);     chk({tag, "_reg_wr"}, reg_wr, 0);
    chk({tag, "_bad"}, bad_frame_count, 0); chk({tag, "_busy"}, busy, 0);
    chk({tag, "_addr"}, reg_addr, 0);   chk({tag, "_data"}, reg_data, 0);
  endtask

  initial begin
    int ok;
    #13; chk_reset_vals("por");
    @(posedge fx2_clk); #3 reset = 1'b0;

    // Empty FIFO: nothing must happen
    repeat (20) begin
      @(negedge fx2_clk);
      chk("idle_req", bus_req, 0); chk("idle_slrd", fx2_slrd, 1); chk("idle_busy", busy, 0);
    end

    // Garbage then a command
    start_case();
    push(8'hFF); push(8'hFF); push(8'hFF); push_frame(8'hAA, 8'h01, 8'h01, 8'h01);
    drain(200);
    chk("t2_strobes", strobes, 7);
    chk("t2_nwr", got_wr.size(), 1); chk_wr(0, 16'h0101);
    chk("t2_bad", bad_frame_count, 0);

    // Bad opcode and MAGIC as payload
    start_case();
    push_frame(8'hAA, 8'h01, 8'h01, 8'h02);
    push_frame(8'hAA, 8'h07, 8'h00, 8'h00);
    push_frame(8'hAA, 8'h01, 8'hAA, 8'hAA);
    drain(300);
    chk("t3_nwr", got_wr.size(), 2); chk_wr(0, 16'h0102); chk_wr(1, 16'hAAAA);
    chk("t3_bad", bad_frame_count, 1);

    // Burst limit with a frame straddling two grants
    start_case();
    for (int i = 0; i < 5; i++) push_frame(8'hAA, 8'h01, 8'(8'h10 + i), 8'(8'h20 + i));
    drain(400);
    chk("t4_nbursts", bursts.size(), 2);
    if (bursts.size() == 2) begin chk("t4_burst0", bursts[0], 16); chk("t4_burst1", bursts[1], 4); end
    chk("t4_nwr", got_wr.size(), 5);
    for (int i = 0; i < 5; i++) chk_wr(i, {8'(8'h10 + i), 8'(8'h20 + i)});

    // Grant withheld, then dropped during a strobe
    start_case();
    gnt_mode = 1; gnt_val = 1'b0;
    push_frame(8'hAA, 8'h01, 8'h33, 8'h44);
    repeat (3) @(negedge fx2_clk);
    repeat (50) begin
      @(negedge fx2_clk);
      chk("nogrant_req", bus_req, 1); chk("nogrant_slrd", fx2_slrd, 1); chk("nogrant_sloe", fx2_sloe, 1);
    end
    gnt_val = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge fx2_clk); if (!fx2_slrd) ok = 1; end
    chk("drop_strobe_seen", ok, 1);
    gnt_val = 1'b0;
    @(negedge fx2_clk); @(negedge fx2_clk);
    chk("drop_sloe", fx2_sloe, 1); chk("drop_req", bus_req, 0);
    chk("drop_byte_done", strobes, 1);
    repeat (5) @(negedge fx2_clk);
    gnt_mode = 0;
    drain(200);
    chk("t5_nwr", got_wr.size(), 1); chk_wr(0, 16'h3344);

    // Partial frame killed by reset
    start_case();
    push(8'hAA); push(8'h01);
    drain(100);
    @(posedge fx2_clk); #3 reset = 1'b1;
    @(posedge fx2_clk); #3 reset = 1'b0;
    push(8'h01); push(8'h01); push_frame(8'hAA, 8'h01, 8'h05, 8'h09);
    drain(200);
    chk("t6_nwr", got_wr.size(), 1); chk_wr(0, 16'h0509);
    chk("t6_bad", bad_frame_count, 0);

    // Saturation of the bad-frame counter
    for (int i = 0; i < 260; i++) begin push(8'hAA); push(8'h07); end
    drain(4000);
    chk("sat_bad", bad_frame_count, 255);

    // Randomised traffic with a random grant
    start_case();
    m_writes = 0;
    gnt_mode = 2;
    for (int it = 0; it < 150; it++) begin
      @(posedge fx2_clk); #2;
      case ($urandom_range(0, 3))
        0, 1: push_frame(8'hAA, 8'h01, ($urandom_range(0, 3) == 0) ? 8'hAA : 8'($urandom),
                         ($urandom_range(0, 3) == 0) ? 8'hAA : 8'($urandom));
        2:    begin push(8'hAA); push(($urandom_range(0, 1) == 0) ? 8'hAA : 8'($urandom_range(2, 255))); end
        default: push(8'($urandom_range(0, 8'hA9)));
      endcase
      repeat ($urandom_range(0, 12)) @(posedge fx2_clk);
    end
    drain(6000);
    gnt_mode = 0;
    chk("rand_nwr", got_wr.size(), m_writes);

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 3; i++) push_frame(8'hAA, 8'h01, 8'h77, 8'h66);
    push_frame(8'hAA, 8'h09, 8'h00, 8'h00);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin @(negedge fx2_clk); if (!fx2_slrd && reg_addr == 8'h77) ok = 1; end
    chk("mid_reset_active", ok, 1);
    @(posedge fx2_clk); #3 reset = 1'b1;
    #1 chk_reset_vals("async");
    fifo.delete();
    @(posedge fx2_clk); #3 reset = 1'b0;
    repeat (10) @(negedge fx2_clk);
    chk("post_reset_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: bench did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
endmodule

// File: doc/fx2_cmd_reader.md
Name: fx2_cmd_reader

Overview:
- FPGA-side consumer of the host command stream on the FX2 slave-FIFO interface.
- Arbitrates for the shared FX2 bus, drains the EP2 OUT FIFO one byte at a time and parses 4-byte command frames (MAGIC, opcode, addr, data).
- Emits single-cycle register-write strobes to the timetag control register file.
- Sits beside the IN-endpoint writer inside fx2_timetag. A top-level arbiter grants the bus to either block.

Parameters:
EP_ADDR, 2'b00, FIFOADR value selecting EP2 OUT
MAGIC, 8'hAA, frame start byte
OP_WRITE, 8'h01, register-write opcode
MAX_BURST, 16, maximum bytes read per bus grant (1..255)

Ports:
fx2_clk  in  1  FX2 interface clock; all logic on its rising edge
reset  in  1  asynchronous, active-high
fx2_flags  in  3  flags[0]=1 means EP2 OUT FIFO not empty; flags[2:1] unused here
fx2_fd  in  8  FIFO data bus (tristate resolved at top level)
fx2_slrd  out  1  read strobe, active-low
fx2_sloe  out  1  FIFO output enable, active-low
fx2_fifoadr  out  2  endpoint select
bus_req  out  1  request shared FX2 bus
bus_gnt  in  1  bus granted
reg_wr  out  1  one-cycle register write strobe
reg_addr  out  8  write address, valid with reg_wr
reg_data  out  8  write data, valid with reg_wr
bad_frame_count  out  8  saturating count of frames rejected for a bad opcode
busy  out  1  high whenever the bus FSM is not in IDLE

Behaviour:

Reset values (asynchronous):
- fx2_slrd=1, fx2_sloe=1, fx2_fifoadr=EP_ADDR, bus_req=0.
- reg_wr=0, reg_addr=0, reg_data=0, bad_frame_count=0, busy=0.
- Burst counter=0. Both FSMs return to their initial states.

Bus FSM (IDLE, WAIT_GNT, SETUP, STROBE, SETTLE, RELEASE):
- IDLE: if flags[0] -> WAIT_GNT and assert bus_req.
- WAIT_GNT: hold bus_req. When bus_gnt=1 -> SETUP. No FX2 pins are driven low before the grant.
- SETUP (1 cycle):
  - Drive fifoadr=EP_ADDR and sloe=0; clear the burst counter.
  - -> STROBE if flags[0] and bus_gnt, else RELEASE.
- STROBE (1 cycle):
  - slrd=0. fx2_fd is sampled at the end of this cycle and passed to the parser. Burst counter +1.
  - -> SETTLE.
  - A grant drop during STROBE does not abort the byte.
- SETTLE (1 cycle):
  - slrd=1, which gives the empty flag time to update.
  - -> STROBE if flags[0], bus_gnt and counter<MAX_BURST, else RELEASE.
- RELEASE (1 cycle): sloe=1, bus_req=0 -> IDLE.
- Throughput is 1 byte per 2 cycles.
- Re-request requires one IDLE cycle after RELEASE.

Parser FSM (WAIT_MAGIC, OPCODE, ADDR, DATA), advanced only on sampled bytes:
- WAIT_MAGIC: byte==MAGIC -> OPCODE. Any other byte is silently discarded and not counted.
- OPCODE:
  - byte==OP_WRITE -> ADDR.
  - Otherwise bad_frame_count +1 (saturates at 255) -> WAIT_MAGIC.
  - A MAGIC byte in this slot is treated as a bad opcode.
- ADDR: latch the address -> DATA. The value 0xAA is legal here.
- DATA:
  - Latch the data. The next cycle drives reg_wr=1 with reg_addr/reg_data.
  - -> WAIT_MAGIC.
  - The value 0xAA is legal here.
- reg_addr/reg_data hold their values until the next write.

Latency and boundaries:
- reg_wr rises 1 cycle after the STROBE cycle that carried the DATA byte.
- Frames may span bursts. Parser state is independent of bus ownership and is preserved across RELEASE.
- Empty FIFO mid-frame: the parser waits indefinitely. There is no timeout.
- Reset mid-frame discards the partial frame.

Decomposition:
- Package fx2_cmd_pkg:
  - MAGIC and OP_WRITE default constants.
  - Bus-FSM and parser-FSM state enums.
  - Frame length constant (4).
- Sub-module fx2_cmd_parser:
  - Interface: byte_valid/byte_data in; reg_wr/reg_addr/reg_data/bad_frame_count out.
  - Instantiated once by fx2_cmd_reader, which keeps the bus FSM.

Test Plan:
1. Reset:
   - Assert reset asynchronously mid-cycle -> slrd=1, sloe=1, bus_req=0, reg_wr=0, bad_frame_count=0 immediately.
   - No strobes occur while flags[0]=0.
2. Garbage then command:
   - FIFO holds FF FF FF AA 01 01 01 and the grant is immediate -> 7 slrd pulses, each 1 low / 1 high cycle.
   - Exactly one reg_wr with addr=01, data=01; bad_frame_count=0.
3. Stop command and magic as payload:
   - AA 01 01 02 -> reg_wr addr=01 data=02.
   - AA 07 00 00 -> bad_frame_count=1, no write.
   - AA 01 AA AA -> reg_wr addr=AA data=AA.
4. Burst limit:
   - 20 queued bytes forming 5 frames, MAX_BURST=16 -> 16 strobes, RELEASE, IDLE, re-request, 4 strobes.
   - 5 reg_wr pulses in order; the frame split across bursts decodes correctly.
5. Arbitration:
   - bus_gnt held low for 50 cycles -> bus_req=1, slrd/sloe stay high.
   - bus_gnt dropped during STROBE -> that byte completes, then RELEASE; sloe=1 and bus_req=0 within 2 cycles.
6. Reset mid-frame:
   - AA 01 read, reset pulsed, then 01 01 AA 01 05 09 -> only reg_wr addr=05 data=09.
   - bad_frame_count=0.
